// File: rtl/jtoutrun_rdarb_pkg.sv
// Shared types and default widths for the road-ROM read arbiter.
package jtoutrun_rdarb_pkg;
  localparam int AW_DEF = 14;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {IDLE, SETTLE, WAIT} state_t;
endpackage

// File: rtl/jtoutrun_rdarb_buf.sv
// Single-entry line buffer: last fetched word, its tag and a valid bit, with hit compare.
module jtoutrun_rdarb_buf
  import jtoutrun_rdarb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          fill,
  input  logic [AW-1:0] fill_addr,
  input  logic [DW-1:0] fill_data,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] data,
  output logic          ok,
  output logic          pend
);
  logic [AW-1:0] tag;
  logic          valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag   <= '0;
      data  <= '0;
      valid <= 1'b0;
    end else begin
      if (fill) begin
        tag  <= fill_addr;
        data <= fill_data;
      end
      // flush wins over a fill landing on the same edge
      valid <= flush ? 1'b0 : (fill | valid);
    end
  end

  assign ok   = cs & valid & (tag == addr);
  assign pend = cs & ~ok;
endmodule

// File: rtl/jtoutrun_rdarb.sv
// Two-requester road ROM arbiter sharing one SDRAM slot.
// Optional hit/fetch statistics when JTOUTRUN_RDARB_STATS_EN is defined.
module jtoutrun_rdarb
  import jtoutrun_rdarb_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int SETTLE = 1
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          rom0_cs,
  input  logic [AW-1:0] rom0_addr,
  output logic [DW-1:0] rom0_data,
  output logic          rom0_ok,
  input  logic          rom1_cs,
  input  logic [AW-1:0] rom1_addr,
  output logic [DW-1:0] rom1_data,
  output logic          rom1_ok,
  output logic          sdram_cs,
  output logic [AW-1:0] sdram_addr,
  input  logic [DW-1:0] sdram_data,
  input  logic          sdram_ok
`ifdef JTOUTRUN_RDARB_STATS_EN
  ,
  input  logic          hs,
  input  logic [1:0]    st_addr,
  output logic [7:0]    st_dout
`endif
);
  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0]         cs_v, ok_v, pend_v, fill_v;
  logic [NUM_LANES-1:0][AW-1:0] addr_v;
  logic [NUM_LANES-1:0][DW-1:0] data_v;

  state_t        state, state_nx;
  logic [1:0]    cnt, cnt_nx;
  logic          grant, grant_nx, last_grant, lg_nx, cs_nx;
  logic [AW-1:0] addr_nx;

  assign cs_v   = {rom1_cs, rom0_cs};
  assign addr_v = {rom1_addr, rom0_addr};

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      jtoutrun_rdarb_buf #(.AW(AW), .DW(DW)) u_lbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .fill      (fill_v[i]),
        .fill_addr (sdram_addr),
        .fill_data (sdram_data),
        .cs        (cs_v[i]),
        .addr      (addr_v[i]),
        .data      (data_v[i]),
        .ok        (ok_v[i]),
        .pend      (pend_v[i])
      );
    end
  endgenerate

  assign rom0_data = data_v[0];
  assign rom1_data = data_v[1];
  assign rom0_ok   = ok_v[0];
  assign rom1_ok   = ok_v[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      grant      <= 1'b0;
      last_grant <= 1'b0;
      sdram_cs   <= 1'b0;
      sdram_addr <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      grant      <= grant_nx;
      last_grant <= lg_nx;
      sdram_cs   <= cs_nx;
      sdram_addr <= addr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    grant_nx = grant;
    lg_nx    = last_grant;
    cs_nx    = sdram_cs;
    addr_nx  = sdram_addr;
    fill_v   = '0;
    case (state)
      IDLE: if (|pend_v) begin
        grant_nx = (&pend_v) ? ~last_grant : pend_v[1];
        addr_nx  = addr_v[grant_nx];
        cs_nx    = 1'b1;
        cnt_nx   = 2'(SETTLE);
        state_nx = jtoutrun_rdarb_pkg::SETTLE;
      end
      // sdram_ok may still belong to the previous address here
      jtoutrun_rdarb_pkg::SETTLE: begin
        cnt_nx = cnt - 2'd1;
        if (cnt == 2'd1) state_nx = WAIT;
      end
      WAIT: if (sdram_ok) begin
        fill_v[grant]  = 1'b1;
        fill_v[~grant] = pend_v[~grant] & (addr_v[~grant] == sdram_addr);
        cs_nx    = 1'b0;
        lg_nx    = grant;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef JTOUTRUN_RDARB_STATS_EN
  // Index order matches st_addr: hit0, fetch0, hit1, fetch1
  logic            hs_l;
  logic [3:0]      inc;
  logic [3:0][7:0] st_cnt, st_snap;

  assign inc = {fetch_ev(1'b1), ok_v[1], fetch_ev(1'b0), ok_v[0]};

  function automatic logic fetch_ev(input logic lane);
    return (state == IDLE) && (|pend_v) && (grant_nx == lane);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_l    <= 1'b0;
      st_cnt  <= '0;
      st_snap <= '0;
    end else begin
      hs_l <= hs;
      if (hs && !hs_l) begin
        st_snap <= st_cnt;
        st_cnt  <= '0;
      end else begin
        for (int k = 0; k < 4; k++)
          if (inc[k] && st_cnt[k] != 8'hff) st_cnt[k] <= st_cnt[k] + 8'd1;
      end
    end
  end

  assign st_dout = st_snap[st_addr];
`endif
endmodule

// File: tb/tb_jtoutrun_rdarb.sv
// Directed bench for jtoutrun_rdarb (default build, SETTLE=1).
module tb_jtoutrun_rdarb;
  logic        clk = 0, rst_n = 0, flush = 0;
  logic        rom0_cs = 0, rom1_cs = 0, sdram_ok = 0;
  logic [13:0] rom0_addr = 0, rom1_addr = 0;
  logic [15:0] rom0_data, rom1_data, sdram_data = 0;
  logic        rom0_ok, rom1_ok, sdram_cs;
  logic [13:0] sdram_addr;

  int tests = 0, fails = 0, nfetch = 0;
  logic cs_q = 0;

  jtoutrun_rdarb #(.AW(14), .DW(16), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .rom0_cs(rom0_cs), .rom0_addr(rom0_addr), .rom0_data(rom0_data), .rom0_ok(rom0_ok),
    .rom1_cs(rom1_cs), .rom1_addr(rom1_addr), .rom1_data(rom1_data), .rom1_ok(rom1_ok),
    .sdram_cs(sdram_cs), .sdram_addr(sdram_addr), .sdram_data(sdram_data), .sdram_ok(sdram_ok)
  );

  always #5 clk = ~clk;

  // count SDRAM fetches as rising edges of sdram_cs
  always @(negedge clk) begin
    if (sdram_cs && !cs_q) nfetch++;
    cs_q = sdram_cs;
  end

  function automatic logic [15:0] mem(input logic [13:0] a);
    if (a == 14'h0123) return 16'hBEEF;
    return {a[7:0], ~a[7:0]};
  endfunction

  // Wait for a request, then answer lat cycles after sdram_cs rose
  task automatic serve(input int lat, output logic [13:0] a);
    bit seen = 0;
    a = '0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (sdram_cs) seen = 1;
    end
    tests++;
    if (!seen) begin
      fails++; $display("FAIL serve_timeout got sdram_cs=0 exp 1");
    end else begin
      a = sdram_addr;
      repeat (lat - 1) @(negedge clk);
      sdram_ok = 1; sdram_data = mem(a);
      @(negedge clk);
      sdram_ok = 0; sdram_data = 16'h0;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    tests++; if (sdram_cs !== 1'b0) begin fails++; $display("FAIL rst_cs got %b exp 0", sdram_cs); end
    tests++; if (sdram_addr !== 14'h0) begin fails++; $display("FAIL rst_addr got %h exp 0", sdram_addr); end
    tests++; if ({rom0_ok, rom1_ok} !== 2'b00) begin fails++; $display("FAIL rst_ok got %b exp 00", {rom0_ok, rom1_ok}); end
    tests++; if (rom0_data !== 16'h0) begin fails++; $display("FAIL rst_data got %h exp 0", rom0_data); end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_single_miss;
    logic [13:0] a; int n0;
    n0 = nfetch;
    rom0_cs = 1; rom0_addr = 14'h0123;
    #1;
    tests++; if (rom0_ok !== 1'b0) begin fails++; $display("FAIL single_miss_ok got %b exp 0", rom0_ok); end
    serve(4, a);
    tests++; if (a !== 14'h0123) begin fails++; $display("FAIL single_addr got %h exp 0123", a); end
    #1;
    tests++; if (rom0_ok !== 1'b1) begin fails++; $display("FAIL single_ok got %b exp 1", rom0_ok); end
    tests++; if (rom0_data !== 16'hBEEF) begin fails++; $display("FAIL single_data got %h exp beef", rom0_data); end
    rom0_cs = 0;
    @(negedge clk);
    rom0_cs = 1;
    #1;
    tests++; if (rom0_ok !== 1'b1) begin fails++; $display("FAIL single_rehit got %b exp 1", rom0_ok); end
    repeat (3) @(negedge clk);
    #1;
    tests++; if (nfetch - n0 !== 1) begin fails++; $display("FAIL single_nfetch got %0d exp 1", nfetch - n0); end
  endtask

  task automatic test_both_miss;
    logic [13:0] a;
    rom0_cs = 1; rom0_addr = 14'h0010; rom1_cs = 1; rom1_addr = 14'h0020;
    serve(3, a);
    tests++; if (a !== 14'h0020) begin fails++; $display("FAIL both_first got %h exp 0020", a); end
    #1;
    tests++; if ({rom1_ok, rom0_ok} !== 2'b10) begin fails++; $display("FAIL both_ok1 got %b exp 10", {rom1_ok, rom0_ok}); end
    serve(3, a);
    tests++; if (a !== 14'h0010) begin fails++; $display("FAIL both_second got %h exp 0010", a); end
    #1;
    tests++; if (rom0_data !== mem(14'h0010)) begin fails++; $display("FAIL both_d0 got %h exp %h", rom0_data, mem(14'h0010)); end
    tests++; if (rom1_data !== mem(14'h0020)) begin fails++; $display("FAIL both_d1 got %h exp %h", rom1_data, mem(14'h0020)); end
    // rom0 was granted last, so the next pair goes to rom1
    rom0_addr = 14'h0030; rom1_addr = 14'h0040;
    serve(3, a);
    tests++; if (a !== 14'h0040) begin fails++; $display("FAIL pair2_first got %h exp 0040", a); end
    // rom1 misses again at once: both pending, rom0 must win now
    rom1_addr = 14'h0050;
    serve(3, a);
    tests++; if (a !== 14'h0030) begin fails++; $display("FAIL alt_second got %h exp 0030", a); end
    serve(3, a);
    tests++; if (a !== 14'h0050) begin fails++; $display("FAIL alt_third got %h exp 0050", a); end
    #1;
    tests++; if ({rom1_ok, rom0_ok} !== 2'b11) begin fails++; $display("FAIL alt_ok got %b exp 11", {rom1_ok, rom0_ok}); end
  endtask

  task automatic test_shared_fill;
    logic [13:0] a; int n0;
    @(negedge clk);
    n0 = nfetch;
    rom0_addr = 14'h3FFF; rom1_addr = 14'h3FFF;
    serve(3, a);
    #1;
    tests++; if ({rom1_ok, rom0_ok} !== 2'b11) begin fails++; $display("FAIL shared_ok got %b exp 11", {rom1_ok, rom0_ok}); end
    tests++; if (rom0_data !== 16'hFF00 || rom1_data !== 16'hFF00) begin fails++; $display("FAIL shared_data got %h/%h exp ff00", rom0_data, rom1_data); end
    repeat (4) @(negedge clk);
    #1;
    tests++; if (nfetch - n0 !== 1) begin fails++; $display("FAIL shared_nfetch got %0d exp 1", nfetch - n0); end
  endtask

  task automatic test_stale_ok;
    rom1_cs = 0;
    rom0_addr = 14'h0200; sdram_ok = 1; sdram_data = 16'hDEAD;
    @(negedge clk);
    tests++; if (sdram_cs !== 1'b1) begin fails++; $display("FAIL stale_cs got %b exp 1", sdram_cs); end
    @(negedge clk);
    tests++; if (rom0_ok !== 1'b0) begin fails++; $display("FAIL stale_settle got %b exp 0", rom0_ok); end
    sdram_ok = 0;
    @(negedge clk);
    sdram_ok = 1; sdram_data = mem(14'h0200);
    @(negedge clk);
    sdram_ok = 0;
    #1;
    tests++; if (rom0_ok !== 1'b1) begin fails++; $display("FAIL stale_ok got %b exp 1", rom0_ok); end
    tests++; if (rom0_data !== 16'h00FF) begin fails++; $display("FAIL stale_data got %h exp 00ff", rom0_data); end
  endtask

  task automatic test_flush;
    logic [13:0] a; int n0;
    rom0_cs = 0; flush = 1;
    @(negedge clk);
    flush = 0; rom0_cs = 1;
    #1;
    tests++; if (rom0_ok !== 1'b0) begin fails++; $display("FAIL flush_clear got %b exp 0", rom0_ok); end
    n0 = nfetch;
    serve(3, a);
    #1;
    tests++; if (rom0_ok !== 1'b1 || nfetch - n0 !== 1) begin fails++; $display("FAIL flush_refetch got ok=%b n=%0d exp ok=1 n=1", rom0_ok, nfetch - n0); end
    // flush on the same edge as the fill
    rom0_cs = 0; rom1_cs = 1; rom1_addr = 14'h0300;
    repeat (2) @(negedge clk);
    sdram_ok = 1; sdram_data = mem(14'h0300); flush = 1;
    @(negedge clk);
    sdram_ok = 0; flush = 0;
    #1;
    tests++; if (rom1_ok !== 1'b0 || sdram_cs !== 1'b0) begin fails++; $display("FAIL flush_fill got ok=%b cs=%b exp 0 0", rom1_ok, sdram_cs); end
    @(negedge clk);
    tests++; if (sdram_cs !== 1'b1 || sdram_addr !== 14'h0300) begin fails++; $display("FAIL flush_again got cs=%b a=%h exp 1 0300", sdram_cs, sdram_addr); end
    @(negedge clk);
    sdram_ok = 1; sdram_data = mem(14'h0300);
    @(negedge clk);
    sdram_ok = 0;
    #1;
    tests++; if (rom1_ok !== 1'b1 || rom1_data !== 16'h00FF) begin fails++; $display("FAIL flush_fill2 got ok=%b d=%h exp 1 00ff", rom1_ok, rom1_data); end
  endtask

  task automatic test_async_reset;
    rom0_cs = 1; rom0_addr = 14'h0400;
    repeat (2) @(negedge clk);
    tests++; if (sdram_cs !== 1'b1 || rom1_ok !== 1'b1) begin fails++; $display("FAIL arst_pre got cs=%b ok1=%b exp 1 1", sdram_cs, rom1_ok); end
    #2 rst_n = 0;
    #1;
    tests++; if (sdram_cs !== 1'b0) begin fails++; $display("FAIL arst_cs got %b exp 0", sdram_cs); end
    tests++; if ({rom1_ok, rom0_ok} !== 2'b00) begin fails++; $display("FAIL arst_ok got %b exp 00", {rom1_ok, rom0_ok}); end
    rom0_cs = 0; rom1_cs = 0; sdram_ok = 1; sdram_data = 16'h1234;
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    tests++; if (sdram_cs !== 1'b0) begin fails++; $display("FAIL arst_idle got %b exp 0", sdram_cs); end
    sdram_ok = 0;
    rom1_cs = 1; rom1_addr = 14'h0300;
    #1;
    tests++; if (rom1_ok !== 1'b0) begin fails++; $display("FAIL arst_empty got %b exp 0", rom1_ok); end
  endtask

  initial begin
    test_reset;
    test_single_miss;
    test_both_miss;
    test_shared_fill;
    test_stale_ok;
    test_flush;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
